// File: rtl/acc_tile_counter.sv
// Psum row/tile counter for one layer: counts psum beats per tile, then drains
// PE_SIZE ofmap beats over a valid/ready handshake and pulses the psum FIFO reset.
module acc_tile_counter #(
  parameter int PE_SIZE      = 14,
  parameter int MAX_ROW_NUM  = 1024,
  parameter int MAX_TILE_NUM = 64,
  parameter int ROW_W        = $clog2(MAX_ROW_NUM + 1),
  parameter int TILE_W       = $clog2(MAX_TILE_NUM + 1),
  parameter int IDX_W        = $clog2(PE_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ROW_W-1:0]  cfg_row_num_i,
  input  logic [TILE_W-1:0] cfg_tile_num_i,
  input  logic              psum_en_i,
  input  logic              ofmap_ready_i,
  output logic              busy_o,
  output logic [ROW_W-1:0]  row_cnt_o,
  output logic [TILE_W-1:0] tile_cnt_o,
  output logic              tile_done_o,
  output logic              ofmap_valid_o,
  output logic [IDX_W-1:0]  ofmap_idx_o,
  output logic              fifo_rst_n_o,
  output logic              done_o,
  output logic              psum_err_o,
  output logic              cfg_err_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FLUSH} state_t;

  state_t            state;
  logic [ROW_W-1:0]  row_num;
  logic [TILE_W-1:0] tile_num;
  logic              aborted;

  logic cfg_ok, last_row, last_tile, last_beat;

  assign cfg_ok    = (cfg_row_num_i  != '0) && (cfg_row_num_i  <= ROW_W'(MAX_ROW_NUM)) &&
                     (cfg_tile_num_i != '0) && (cfg_tile_num_i <= TILE_W'(MAX_TILE_NUM));
  assign last_row  = (row_cnt_o  == row_num  - ROW_W'(1));
  assign last_tile = (tile_cnt_o == tile_num - TILE_W'(1));
  assign last_beat = (ofmap_idx_o == IDX_W'(PE_SIZE - 1));

  // NOTE: all state and outputs are registers written with <= so every read
  // below sees the pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      row_num       <= '0;
      tile_num      <= '0;
      aborted       <= 1'b0;
      busy_o        <= 1'b0;
      row_cnt_o     <= '0;
      tile_cnt_o    <= '0;
      tile_done_o   <= 1'b0;
      ofmap_valid_o <= 1'b0;
      ofmap_idx_o   <= '0;
      fifo_rst_n_o  <= 1'b1;
      done_o        <= 1'b0;
      psum_err_o    <= 1'b0;
      cfg_err_o     <= 1'b0;
    end else begin
      // NOTE: pulse outputs get a default first so each branch only asserts them.
      tile_done_o  <= 1'b0;
      done_o       <= 1'b0;
      cfg_err_o    <= 1'b0;
      fifo_rst_n_o <= 1'b1;

      if (psum_en_i && state != ACCUM) psum_err_o <= 1'b1;

      case (state)
        IDLE: begin
          if (start_i) begin
            if (cfg_ok) begin
              row_num     <= cfg_row_num_i;
              tile_num    <= cfg_tile_num_i;
              row_cnt_o   <= '0;
              tile_cnt_o  <= '0;
              ofmap_idx_o <= '0;
              aborted     <= 1'b0;
              psum_err_o  <= 1'b0;
              busy_o      <= 1'b1;
              state       <= ACCUM;
            end else begin
              cfg_err_o <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (abort_i) begin
            aborted      <= 1'b1;
            fifo_rst_n_o <= 1'b0;
            state        <= FLUSH;
          end else if (psum_en_i) begin
            if (last_row) begin
              row_cnt_o   <= '0;
              tile_cnt_o  <= tile_cnt_o + TILE_W'(1);
              tile_done_o <= 1'b1;
              if (last_tile) begin
                ofmap_valid_o <= 1'b1;
                state         <= DRAIN;
              end
            end else begin
              row_cnt_o <= row_cnt_o + ROW_W'(1);
            end
          end
        end

        DRAIN: begin
          if (abort_i) begin
            aborted       <= 1'b1;
            ofmap_valid_o <= 1'b0;
            fifo_rst_n_o  <= 1'b0;
            state         <= FLUSH;
          end else if (ofmap_ready_i) begin
            if (last_beat) begin
              ofmap_valid_o <= 1'b0;
              fifo_rst_n_o  <= 1'b0;
              state         <= FLUSH;
            end else begin
              ofmap_idx_o <= ofmap_idx_o + IDX_W'(1);
            end
          end
        end

        FLUSH: begin
          busy_o <= 1'b0;
          done_o <= !aborted;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_tile_counter.sv
// Directed bench for acc_tile_counter: a vector table for short cases plus
// hand-written sequences for full layers, stalled drain, abort and reset.
module tb_acc_tile_counter;

  localparam int ROW_W  = 11;
  localparam int TILE_W = 7;
  localparam int IDX_W  = 4;

  logic clk = 1'b0;
  logic rst, start_i, abort_i, psum_en_i, ofmap_ready_i;
  logic [ROW_W-1:0]  cfg_row_num_i;
  logic [TILE_W-1:0] cfg_tile_num_i;
  logic busy_o, tile_done_o, ofmap_valid_o, fifo_rst_n_o, done_o, psum_err_o, cfg_err_o;
  logic [ROW_W-1:0]  row_cnt_o;
  logic [TILE_W-1:0] tile_cnt_o;
  logic [IDX_W-1:0]  ofmap_idx_o;

  always #5 clk = ~clk;

  acc_tile_counter dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .cfg_row_num_i(cfg_row_num_i), .cfg_tile_num_i(cfg_tile_num_i),
    .psum_en_i(psum_en_i), .ofmap_ready_i(ofmap_ready_i),
    .busy_o(busy_o), .row_cnt_o(row_cnt_o), .tile_cnt_o(tile_cnt_o),
    .tile_done_o(tile_done_o), .ofmap_valid_o(ofmap_valid_o), .ofmap_idx_o(ofmap_idx_o),
    .fifo_rst_n_o(fifo_rst_n_o), .done_o(done_o), .psum_err_o(psum_err_o),
    .cfg_err_o(cfg_err_o)
  );

  typedef struct {
    logic              rst, start, abort, psum, ready;
    logic [ROW_W-1:0]  row;
    logic [TILE_W-1:0] tile;
    logic              busy;
    logic [ROW_W-1:0]  row_cnt;
    logic [TILE_W-1:0] tile_cnt;
    logic              td, valid;
    logic [IDX_W-1:0]  idx;
    logic              frn, done, perr, cerr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int td_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs are applied, then one clock edge, then outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (tile_done_o) td_seen++;
  endtask

  task automatic idle_inputs();
    rst = 0; start_i = 0; abort_i = 0; psum_en_i = 0; ofmap_ready_i = 0;
  endtask

  task automatic start_layer(input int row, input int tile);
    cfg_row_num_i = ROW_W'(row); cfg_tile_num_i = TILE_W'(tile);
    start_i = 1; tick(); start_i = 0;
  endtask

  task automatic psum_beats(input int n);
    psum_en_i = 1;
    for (int i = 0; i < n; i++) tick();
    psum_en_i = 0;
  endtask

  // Drains one layer; mode 0 = ready always high, mode 1 = ready 1,0,0,1,0,0...
  task automatic drain(input string tag, input int mode);
    int beats = 0;
    int exp_idx = 0;
    logic fire;
    for (int k = 0; k < 200 && beats < 14; k++) begin
      ofmap_ready_i = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      fire = ofmap_valid_o && ofmap_ready_i;
      tick();
      if (fire) begin
        beats++;
        exp_idx++;
      end
      if (beats < 14) begin
        check({tag, " valid during drain"}, ofmap_valid_o, 1);
        check({tag, " idx"}, ofmap_idx_o, exp_idx);
        check({tag, " no early done"}, done_o, 0);
      end
    end
    ofmap_ready_i = 0;
    check({tag, " beat count"}, beats, 14);
    check({tag, " valid drops"}, ofmap_valid_o, 0);
    check({tag, " fifo_rst_n low"}, fifo_rst_n_o, 0);
    check({tag, " busy in flush"}, busy_o, 1);
    check({tag, " done not yet"}, done_o, 0);
    tick();
    check({tag, " fifo_rst_n back high"}, fifo_rst_n_o, 1);
    check({tag, " done pulse"}, done_o, 1);
    check({tag, " busy cleared"}, busy_o, 0);
    tick();
    check({tag, " done one cycle"}, done_o, 0);
  endtask

  function automatic vec_t mk(
      input logic r, s, a, p, rd, input int row, tile,
      input logic busy, input int rc, tc, input logic td, v, input int idx,
      input logic frn, dn, pe, ce);
    vec_t t;
    t.rst = r; t.start = s; t.abort = a; t.psum = p; t.ready = rd;
    t.row = ROW_W'(row); t.tile = TILE_W'(tile);
    t.busy = busy; t.row_cnt = ROW_W'(rc); t.tile_cnt = TILE_W'(tc);
    t.td = td; t.valid = v; t.idx = IDX_W'(idx);
    t.frn = frn; t.done = dn; t.perr = pe; t.cerr = ce;
    return t;
  endfunction

  vec_t vecs[13];

  initial begin
    //                 rst st ab ps rd row   tile busy rc tc td v idx frn dn pe ce
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 0,    1,   0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,    1,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 0, 1,    65,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    vecs[4]  = mk(0, 1, 0, 0, 0, 1025, 1,   0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    vecs[5]  = mk(0, 1, 0, 0, 0, 1,    3,   1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0, 1,    3,   1, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 0, 1,    3,   1, 0, 2, 1, 0, 0, 1, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0, 1,    3,   1, 0, 3, 1, 1, 0, 1, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 1,    3,   1, 0, 3, 0, 1, 0, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 0, 1,    3,   1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 1, 0, 1,    3,   0, 0, 3, 0, 0, 0, 1, 0, 1, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 1,    3,   0, 0, 3, 0, 0, 0, 1, 0, 1, 0);

    idle_inputs();
    cfg_row_num_i = '0; cfg_tile_num_i = '0;
    td_seen = 0;

    // Table: reset, illegal cfgs, row=1 tiles, abort in drain, psum_err in flush.
    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; start_i = vecs[i].start; abort_i = vecs[i].abort;
      psum_en_i = vecs[i].psum; ofmap_ready_i = vecs[i].ready;
      cfg_row_num_i = vecs[i].row; cfg_tile_num_i = vecs[i].tile;
      tick();
      check($sformatf("v%0d busy", i),      busy_o,        vecs[i].busy);
      check($sformatf("v%0d row_cnt", i),   row_cnt_o,     vecs[i].row_cnt);
      check($sformatf("v%0d tile_cnt", i),  tile_cnt_o,    vecs[i].tile_cnt);
      check($sformatf("v%0d tile_done", i), tile_done_o,   vecs[i].td);
      check($sformatf("v%0d valid", i),     ofmap_valid_o, vecs[i].valid);
      check($sformatf("v%0d idx", i),       ofmap_idx_o,   vecs[i].idx);
      check($sformatf("v%0d fifo_rst_n", i), fifo_rst_n_o, vecs[i].frn);
      check($sformatf("v%0d done", i),      done_o,        vecs[i].done);
      check($sformatf("v%0d psum_err", i),  psum_err_o,    vecs[i].perr);
      check($sformatf("v%0d cfg_err", i),   cfg_err_o,     vecs[i].cerr);
    end
    idle_inputs();

    // Full layer: row=70, tile=21, gapped bursts, then unstalled drain.
    start_layer(70, 21);
    check("l1 psum_err cleared by start", psum_err_o, 0);
    td_seen = 0;
    for (int t = 0; t < 21; t++) begin
      for (int g = 0; g < 14; g++) tick();
      if (t == 0) begin
        psum_beats(35);
        check("l1 row_cnt mid tile", row_cnt_o, 35);
        psum_beats(35);
      end else if (t == 20) begin
        psum_beats(69);
        check("l1 valid low before last psum", ofmap_valid_o, 0);
        psum_beats(1);
      end else begin
        psum_beats(70);
      end
    end
    check("l1 valid 1 cycle after last psum", ofmap_valid_o, 1);
    check("l1 tile_done pulses", td_seen, 21);
    check("l1 tile_cnt", tile_cnt_o, 21);
    check("l1 row_cnt wrapped", row_cnt_o, 0);
    check("l1 first idx", ofmap_idx_o, 0);
    drain("l1", 0);

    // Stalled drain with ready pattern 1,0,0.
    start_layer(2, 1);
    psum_beats(2);
    drain("l2", 1);

    // Abort at row 35 of tile 4; start during ACCUM must be ignored.
    start_layer(70, 5);
    psum_beats(3 * 70 + 35);
    check("l5 row_cnt before abort", row_cnt_o, 35);
    check("l5 tile_cnt before abort", tile_cnt_o, 3);
    cfg_row_num_i = ROW_W'(0); cfg_tile_num_i = TILE_W'(0);
    start_i = 1; tick(); start_i = 0;
    check("l5 start ignored row_cnt", row_cnt_o, 35);
    check("l5 start ignored cfg_err", cfg_err_o, 0);
    abort_i = 1; tick(); abort_i = 0;
    check("l5 abort busy in flush", busy_o, 1);
    check("l5 abort fifo_rst_n low", fifo_rst_n_o, 0);
    check("l5 abort no done", done_o, 0);
    tick();
    check("l5 after abort busy", busy_o, 0);
    check("l5 after abort fifo_rst_n", fifo_rst_n_o, 1);
    check("l5 after abort no done", done_o, 0);
    abort_i = 1; tick(); abort_i = 0;
    check("l5 abort in idle ignored", fifo_rst_n_o, 1);

    // psum_err sticky until start, then reset mid-drain.
    psum_en_i = 1; tick(); psum_en_i = 0;
    check("l6 psum_err set in idle", psum_err_o, 1);
    tick();
    check("l6 psum_err sticky", psum_err_o, 1);
    start_layer(2, 1);
    check("l6 psum_err cleared", psum_err_o, 0);
    psum_beats(2);
    ofmap_ready_i = 1; tick(); tick(); ofmap_ready_i = 0;
    psum_en_i = 1; tick(); psum_en_i = 0;
    check("l6 idx before rst", ofmap_idx_o, 2);
    check("l6 psum_err in drain", psum_err_o, 1);
    rst = 1; tick(); rst = 0;
    check("l6 rst busy", busy_o, 0);
    check("l6 rst valid", ofmap_valid_o, 0);
    check("l6 rst idx", ofmap_idx_o, 0);
    check("l6 rst tile_cnt", tile_cnt_o, 0);
    check("l6 rst psum_err", psum_err_o, 0);
    check("l6 rst fifo_rst_n", fifo_rst_n_o, 1);
    tick();
    check("l6 no flush after rst", fifo_rst_n_o, 1);
    check("l6 no done after rst", done_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
